// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
//   div_t     : divisor / counter word
//   MIN_DIV   : smallest divisor a channel will run with
//   clamp_div : raise any divisor below MIN_DIV to MIN_DIV
package clkdiv_pkg;
  localparam int DIV_W   = 16;
  localparam int MIN_DIV = 2;

  typedef logic [DIV_W-1:0] div_t;

  function automatic div_t clamp_div(input div_t v);
    return (v < div_t'(MIN_DIV)) ? div_t'(MIN_DIV) : v;
  endfunction
endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, active divisor, shadow divisor, pending flag.
// The channel is busy while cnt != 0, so a dropped enable always runs the
// current period out to its wrap before the channel parks at cnt=0.
// Ports:
//   clk_in, rst_n       clock, async active-low reset
//   en                  run enable
//   load_strobe/val     divisor write (value is clamped to MIN_DIV)
//   restart             phase-align strobe, overrides everything else
//   clk_out, tick       divided clock and its rising-edge pulse (registered)
//   pending             written divisor waiting for a period boundary
module clk_div_channel
  import clkdiv_pkg::*;
#(
  parameter int CNT_W       = DIV_W,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load_strobe,
  input  logic [CNT_W-1:0] load_val,
  input  logic             restart,
  output logic             clk_out,
  output logic             tick,
  output logic             pending
);
  logic [CNT_W-1:0] cnt, div, shadow, cnt_nxt, low_len, load_c;
  logic             busy, advance, wrap;

  generate
    if (CNT_W == DIV_W) begin : g_clamp_pkg
      assign load_c = clamp_div(load_val);
    end else begin : g_clamp_local
      assign load_c = (load_val < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : load_val;
    end
  endgenerate

  // Low phase is floor(N/2); odd N therefore gets the longer high phase.
  assign low_len = div >> 1;
  assign busy    = (cnt != '0);
  assign advance = en | busy;
  assign wrap    = advance && (cnt == div - CNT_W'(1));

  always_comb begin
    cnt_nxt = cnt;
    if (wrap)         cnt_nxt = '0;
    else if (advance) cnt_nxt = cnt + CNT_W'(1);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      div     <= CNT_W'(DEFAULT_DIV);
      shadow  <= CNT_W'(DEFAULT_DIV);
      pending <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else if (restart) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      pending <= 1'b0;
      if (load_strobe) begin
        div    <= load_c;
        shadow <= load_c;
      end else begin
        div    <= shadow;
      end
    end else begin
      cnt     <= cnt_nxt;
      clk_out <= (cnt_nxt >= low_len);
      tick    <= (cnt_nxt == low_len);
      if (load_strobe) shadow <= load_c;
      if (wrap) begin
        // Period boundary: a write landing on this edge governs the new period.
        div     <= load_strobe ? load_c : shadow;
        pending <= 1'b0;
      end else if (!advance) begin
        // Parked: adopt the shadow on the edge after it was written.
        div     <= shadow;
        pending <= load_strobe;
      end else if (load_strobe) begin
        pending <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/multi_clock_divider.sv
// NUM_CH independent glitch-free clock dividers sharing clk_in.
// The top only decodes the divisor write channel and fans out sync_restart.
// Ports:
//   clk_in, rst_n                      clock, async active-low reset
//   ch_en[NUM_CH]                      per-channel run enable
//   div_wr, div_wr_ch, div_wr_val      divisor write strobe, channel, value
//   sync_restart                       restart all channels in phase
//   clk_out[NUM_CH], tick[NUM_CH]      divided clocks and rising-edge pulses
//   div_pending[NUM_CH]                divisor write awaiting a boundary
module multi_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int  NUM_CH      = 4,
  parameter int  CNT_W       = DIV_W,
  parameter int  DEFAULT_DIV = 4,
  localparam int SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              div_wr,
  input  logic [SEL_W-1:0]  div_wr_ch,
  input  logic [CNT_W-1:0]  div_wr_val,
  input  logic              sync_restart,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] div_pending
);
  logic [NUM_CH-1:0] load_strobe;

  // Out-of-range channel indices match no lane and are dropped.
  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign load_strobe[i] = div_wr && (div_wr_ch == SEL_W'(i));

      clk_div_channel #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .en          (ch_en[i]),
        .load_strobe (load_strobe[i]),
        .load_val    (div_wr_val),
        .restart     (sync_restart),
        .clk_out     (clk_out[i]),
        .tick        (tick[i]),
        .pending     (div_pending[i])
      );
    end
  endgenerate
endmodule

// File: tb/tb_multi_clock_divider.sv
// Directed self-checking bench for multi_clock_divider.
// A second instance with NUM_CH=3 exercises an out-of-range write index.
module tb_multi_clock_divider;
  logic        clk_in = 1'b0;
  logic        rst_n  = 1'b0;
  logic [3:0]  ch_en = '0;
  logic        div_wr = 1'b0;
  logic [1:0]  div_wr_ch = '0;
  logic [15:0] div_wr_val = '0;
  logic        sync_restart = 1'b0;
  logic [3:0]  clk_out, tick, div_pending;
  logic [2:0]  ch_en3 = '0;
  logic [1:0]  div_wr_ch3 = '0;
  logic [2:0]  clk_out3, tick3, pend3;
  int pass_cnt = 0;
  int chk_cnt  = 0;

  always #5 clk_in = ~clk_in;

  multi_clock_divider #(.NUM_CH(4), .CNT_W(16), .DEFAULT_DIV(4)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .ch_en(ch_en), .div_wr(div_wr),
    .div_wr_ch(div_wr_ch), .div_wr_val(div_wr_val), .sync_restart(sync_restart),
    .clk_out(clk_out), .tick(tick), .div_pending(div_pending)
  );

  multi_clock_divider #(.NUM_CH(3), .CNT_W(16), .DEFAULT_DIV(4)) dut3 (
    .clk_in(clk_in), .rst_n(rst_n), .ch_en(ch_en3), .div_wr(div_wr),
    .div_wr_ch(div_wr_ch3), .div_wr_val(div_wr_val), .sync_restart(sync_restart),
    .clk_out(clk_out3), .tick(tick3), .div_pending(pend3)
  );

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    ch_en = '0; div_wr = 1'b0; div_wr_ch = '0; div_wr_val = '0;
    sync_restart = 1'b0; ch_en3 = '0; div_wr_ch3 = '0;
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    ch_en = '0; div_wr = 1'b0; sync_restart = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_cnt++; if (clk_out !== 4'b0) $display("FAIL reset clk_out: got %b want 0000", clk_out); else pass_cnt++;
    chk_cnt++; if (tick !== 4'b0) $display("FAIL reset tick: got %b want 0000", tick); else pass_cnt++;
    chk_cnt++; if (div_pending !== 4'b0) $display("FAIL reset pending: got %b want 0000", div_pending); else pass_cnt++;
    chk_cnt++; if ({clk_out3, tick3, pend3} !== 9'b0) $display("FAIL reset dut3: got %b want 0", {clk_out3, tick3, pend3}); else pass_cnt++;
    step();
    rst_n = 1'b1;
  endtask

  // N=4 from reset: clk 0,1,1,0,... from edge 1, tick on edges 2,6,10.
  task automatic test_default();
    bit ec[10] = '{0,1,1,0,0,1,1,0,0,1};
    bit et[10] = '{0,1,0,0,0,1,0,0,0,1};
    do_reset();
    ch_en = 4'b0001;
    for (int e = 0; e < 10; e++) begin
      step();
      chk_cnt++; if (clk_out !== {3'b000, ec[e]}) $display("FAIL default clk edge %0d: got %b want %b", e+1, clk_out, {3'b000, ec[e]}); else pass_cnt++;
      chk_cnt++; if (tick !== {3'b000, et[e]}) $display("FAIL default tick edge %0d: got %b want %b", e+1, tick, {3'b000, et[e]}); else pass_cnt++;
      chk_cnt++; if (div_pending !== 4'b0) $display("FAIL default pending edge %0d: got %b want 0000", e+1, div_pending); else pass_cnt++;
    end
  endtask

  // N=5 written while idle: pending one cycle, then 2 low / 3 high.
  task automatic test_odd();
    bit ec[10] = '{0,1,1,1,0,0,1,1,1,0};
    bit et[10] = '{0,1,0,0,0,0,1,0,0,0};
    do_reset();
    div_wr = 1'b1; div_wr_ch = 2'd1; div_wr_val = 16'd5;
    step();
    div_wr = 1'b0;
    chk_cnt++; if (div_pending !== 4'b0010) $display("FAIL odd pending set: got %b want 0010", div_pending); else pass_cnt++;
    step();
    chk_cnt++; if (div_pending !== 4'b0000) $display("FAIL odd pending clear: got %b want 0000", div_pending); else pass_cnt++;
    ch_en = 4'b0010;
    for (int e = 0; e < 10; e++) begin
      step();
      chk_cnt++; if (clk_out[1] !== ec[e]) $display("FAIL odd clk1 edge %0d: got %b want %b", e+1, clk_out[1], ec[e]); else pass_cnt++;
      chk_cnt++; if (tick[1] !== et[e]) $display("FAIL odd tick1 edge %0d: got %b want %b", e+1, tick[1], et[e]); else pass_cnt++;
    end
  endtask

  // Running N=4, write 6 at cnt=1: finish the N=4 period, then 3 low / 3 high.
  task automatic test_div_change();
    bit ec[10] = '{1,1,0,0,0,1,1,1,0,0};
    bit et[10] = '{1,0,0,0,0,1,0,0,0,0};
    bit ep[10] = '{1,1,0,0,0,0,0,0,0,0};
    do_reset();
    ch_en = 4'b0001;
    step();
    div_wr = 1'b1; div_wr_ch = 2'd0; div_wr_val = 16'd6;
    for (int e = 0; e < 10; e++) begin
      step();
      div_wr = 1'b0;
      chk_cnt++; if (clk_out[0] !== ec[e]) $display("FAIL change clk0 edge %0d: got %b want %b", e+2, clk_out[0], ec[e]); else pass_cnt++;
      chk_cnt++; if (tick[0] !== et[e]) $display("FAIL change tick0 edge %0d: got %b want %b", e+2, tick[0], et[e]); else pass_cnt++;
      chk_cnt++; if (div_pending[0] !== ep[e]) $display("FAIL change pending0 edge %0d: got %b want %b", e+2, div_pending[0], ep[e]); else pass_cnt++;
    end
  endtask

  // Two writes before the boundary, the second landing on the boundary edge.
  task automatic test_back_to_back();
    bit ec[4] = '{1,1,0,1};
    bit et[4] = '{1,0,0,1};
    do_reset();
    ch_en = 4'b0001;
    step();
    div_wr = 1'b1; div_wr_ch = 2'd0; div_wr_val = 16'd8;
    step();
    div_wr = 1'b0;
    chk_cnt++; if (div_pending[0] !== 1'b1) $display("FAIL b2b pending e2: got %b want 1", div_pending[0]); else pass_cnt++;
    step();
    chk_cnt++; if ({div_pending[0], clk_out[0]} !== 2'b11) $display("FAIL b2b e3 pend/clk: got %b want 11", {div_pending[0], clk_out[0]}); else pass_cnt++;
    div_wr = 1'b1; div_wr_val = 16'd3;
    step();
    div_wr = 1'b0;
    chk_cnt++; if ({div_pending[0], clk_out[0]} !== 2'b00) $display("FAIL b2b e4 pend/clk: got %b want 00", {div_pending[0], clk_out[0]}); else pass_cnt++;
    for (int e = 0; e < 4; e++) begin
      step();
      chk_cnt++; if ({clk_out[0], tick[0]} !== {ec[e], et[e]}) $display("FAIL b2b N3 edge %0d: got %b want %b", e+5, {clk_out[0], tick[0]}, {ec[e], et[e]}); else pass_cnt++;
    end
  endtask

  // Drop enable in the high phase; then drop and restore it mid-period.
  task automatic test_disable();
    bit ec[8] = '{1,0,0,0,0,0,0,0};
    bit rc[6] = '{1,1,0,0,1,1};
    bit rt[6] = '{1,0,0,0,1,0};
    do_reset();
    ch_en = 4'b0001;
    step(); step();
    chk_cnt++; if (tick[0] !== 1'b1) $display("FAIL disable pre tick0: got %b want 1", tick[0]); else pass_cnt++;
    ch_en = 4'b0000;
    for (int e = 0; e < 8; e++) begin
      step();
      chk_cnt++; if ({clk_out[0], tick[0]} !== {ec[e], 1'b0}) $display("FAIL disable edge %0d: got %b want %b", e+3, {clk_out[0], tick[0]}, {ec[e], 1'b0}); else pass_cnt++;
    end
    do_reset();
    ch_en = 4'b0001;
    step();
    ch_en = 4'b0000;
    for (int e = 0; e < 6; e++) begin
      step();
      ch_en = 4'b0001;
      chk_cnt++; if ({clk_out[0], tick[0]} !== {rc[e], rt[e]}) $display("FAIL reenable edge %0d: got %b want %b", e+2, {clk_out[0], tick[0]}, {rc[e], rt[e]}); else pass_cnt++;
    end
  endtask

  // ch0 N=4 and ch1 N=6 out of phase, then sync_restart aligns them.
  task automatic test_sync_restart();
    bit c0, c1, t0, t1;
    do_reset();
    div_wr = 1'b1; div_wr_ch = 2'd1; div_wr_val = 16'd6;
    step();
    div_wr = 1'b0;
    step();
    ch_en = 4'b0001;
    step();
    ch_en = 4'b0011;
    step(); step();
    chk_cnt++; if (clk_out[1:0] !== 2'b01) $display("FAIL sync pre phase: got %b want 01", clk_out[1:0]); else pass_cnt++;
    sync_restart = 1'b1;
    step();
    sync_restart = 1'b0;
    chk_cnt++; if ({clk_out[1:0], tick[1:0]} !== 4'b0000) $display("FAIL sync restart edge: got %b want 0000", {clk_out[1:0], tick[1:0]}); else pass_cnt++;
    for (int k = 1; k <= 13; k++) begin
      step();
      c0 = (k % 4 >= 2); t0 = (k % 4 == 2);
      c1 = (k % 6 >= 3); t1 = (k % 6 == 3);
      chk_cnt++; if ({clk_out[1:0], tick[1:0]} !== {c1, c0, t1, t0}) $display("FAIL sync k=%0d: got %b want %b", k, {clk_out[1:0], tick[1:0]}, {c1, c0, t1, t0}); else pass_cnt++;
    end
  endtask

  // Divisors 0 and 1 clamp to 2; bad index ignored; async reset mid-high.
  task automatic test_clamp_and_edges();
    bit c;
    for (int v = 0; v < 2; v++) begin
      do_reset();
      div_wr = 1'b1; div_wr_ch = 2'd2; div_wr_val = 16'(v);
      step();
      div_wr = 1'b0;
      step();
      ch_en = 4'b0100;
      for (int e = 1; e <= 6; e++) begin
        step();
        c = (e % 2 == 1);
        chk_cnt++; if ({clk_out[2], tick[2]} !== {c, c}) $display("FAIL clamp v=%0d edge %0d: got %b want %b", v, e, {clk_out[2], tick[2]}, {c, c}); else pass_cnt++;
      end
    end
    do_reset();
    div_wr = 1'b1; div_wr_ch3 = 2'd3; div_wr_val = 16'd7;
    step();
    div_wr = 1'b0;
    chk_cnt++; if (pend3 !== 3'b000) $display("FAIL range pending: got %b want 000", pend3); else pass_cnt++;
    step();
    ch_en3 = 3'b111;
    for (int e = 1; e <= 5; e++) begin
      step();
      c = (e % 4 >= 2);
      chk_cnt++; if (clk_out3 !== {c, c, c}) $display("FAIL range clk edge %0d: got %b want %b", e, clk_out3, {c, c, c}); else pass_cnt++;
    end
    do_reset();
    ch_en = 4'b0001;
    step(); step();
    chk_cnt++; if ({clk_out[0], tick[0]} !== 2'b11) $display("FAIL midreset pre: got %b want 11", {clk_out[0], tick[0]}); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    chk_cnt++; if ({clk_out, tick} !== 8'b0) $display("FAIL midreset async: got %b want 0", {clk_out, tick}); else pass_cnt++;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_default();
    test_odd();
    test_div_change();
    test_back_to_back();
    test_disable();
    test_sync_restart();
    test_clamp_and_edges();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
